// File: rtl/cpu_pkg.sv
// Types and constants shared by the multi-cycle datapath arithmetic blocks
// (divider, multiplier).
package cpu_pkg;

  localparam int WORD_W    = 32;
  localparam int DIV_STEPS = WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// It shifts {rem, quot} left by one, trial-subtracts the divisor, and restores on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH-1:0] shifted;
  logic             carry_out;
  logic [WIDTH:0]   trial;
  logic             borrow;

  // The bit shifted out of rem takes part in the subtract, so the borrow stays exact.
  assign shifted   = {rem[WIDTH-2:0], quot[WIDTH-1]};
  assign carry_out = rem[WIDTH-1];
  assign trial     = {carry_out, shifted} - {1'b0, divisor};
  assign borrow    = trial[WIDTH];

  assign rem_next  = borrow ? shifted : trial[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative signed divider serving the MIPS div instruction. Quotient goes to lo, remainder to hi.
// A zero divisor skips the iteration and raises div_zero alongside done.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quot, quot_n;
  logic [WIDTH-1:0] mag_b, mag_b_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             busy_n, done_n, div_zero_n;

  logic [WIDTH-1:0] step_rem, step_quot;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quot     (quot),
    .divisor  (mag_b),
    .rem_next (step_rem),
    .quot_next(step_quot)
  );

  // The most negative dividend has a magnitude that is still valid as an unsigned value.
  assign mag_a_in = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
  assign mag_b_in = b[WIDTH-1] ? (WIDTH'(0) - b) : b;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quot     <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      rem      <= rem_n;
      quot     <= quot_n;
      mag_b    <= mag_b_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      hi       <= hi_n;
      lo       <= lo_n;
      busy     <= busy_n;
      done     <= done_n;
      div_zero <= div_zero_n;
    end
  end

  // Outputs are computed here one cycle ahead and registered above. busy covers the DONE cycle too.
  always_comb begin
    state_n    = state;
    count_n    = count;
    rem_n      = rem;
    quot_n     = quot;
    mag_b_n    = mag_b;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    hi_n       = hi;
    lo_n       = lo;
    busy_n     = busy;
    done_n     = 1'b0;
    div_zero_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            done_n     = 1'b1;
            div_zero_n = 1'b1;
            state_n    = DONE;
          end else begin
            rem_n   = '0;
            quot_n  = mag_a_in;
            mag_b_n = mag_b_in;
            neg_q_n = a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_n = a[WIDTH-1];
            count_n = '0;
            busy_n  = 1'b1;
            state_n = RUN;
          end
        end
      end

      RUN: begin
        rem_n   = step_rem;
        quot_n  = step_quot;
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_n = FIX;
        end
      end

      FIX: begin
        lo_n    = neg_q ? (WIDTH'(0) - quot) : quot;
        hi_n    = neg_r ? (WIDTH'(0) - rem) : rem;
        done_n  = 1'b1;
        state_n = DONE;
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
